bram_read_checker: RTL and testbench

- Read-side consumer of the dual-port pattern BRAM. The BRAM write port fills word a with value a*2.
- This block sweeps BRAM port B from address 0 to DEPTH-1 after a start request and a settle delay, and compares every returned word against a*2.
- It reports a pass/fail verdict, an error count and the first mismatch.
- It sits in the 100 MHz read domain and drives the enb/addrb port of the block memory directly.

---
 rtl/bram_read_checker.sv | 154 +++++++++++++++
 tb/tb_bram_read_checker.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_checker.sv
// Sweeps BRAM port B over 0..DEPTH-1 after a settle delay and checks each word
// against the a*2 fill pattern, reporting verdict, error count and first mismatch.
module bram_read_checker #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int START_DELAY  = 50
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  input  logic              locked,
  input  logic              start,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [2:0]        fsm_state
);

  // Handshake: start is a single-cycle request sampled only in IDLE/DONE with
  // locked high; busy/done are levels, there is no ready back-pressure.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CNT_MAX = (START_DELAY > READ_LATENCY) ? START_DELAY : READ_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(READ_LATENCY - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [ADDR_W-1:0] pipe_addr [READ_LATENCY];

  logic              accept;
  logic              abort;
  logic              tap_valid;
  logic [ADDR_W-1:0] tap_addr;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;

  assign accept = ((state == S_IDLE) || (state == S_DONE)) && start && locked;
  assign abort  = !locked && ((state == S_WAIT) || (state == S_READ) || (state == S_DRAIN));

  // Compare tap: the pipeline stage that lines up with the returning doutb.
  assign tap_valid = pipe_valid[READ_LATENCY-1];
  assign tap_addr  = pipe_addr[READ_LATENCY-1];
  assign exp_word  = DATA_W'(tap_addr) << 1;
  assign mismatch  = tap_valid && (bram_doutb != exp_word);

  // State register
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; a lock loss outranks everything else in flight.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_n = S_WAIT;
      S_WAIT: begin
        if (abort)                  state_n = S_IDLE;
        else if (cnt == WAIT_LAST)  state_n = S_READ;
      end
      S_READ: begin
        if (abort)                      state_n = S_IDLE;
        else if (addr_cnt == LAST_ADDR) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                  state_n = S_IDLE;
        else if (cnt == DRAIN_LAST) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bram_enb   = (state == S_READ);
    bram_addrb = addr_cnt;
    busy       = (state == S_WAIT) || (state == S_READ) || (state == S_DRAIN);
    done       = (state == S_DONE);
    pass       = (state == S_DONE) && (err_count == 16'd0);
    fsm_state  = state;
  end

  // Counters, compare pipeline and result registers
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      addr_cnt       <= '0;
      pipe_valid     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_addr[i] <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      aborted        <= 1'b0;
    end else if (accept) begin
      cnt            <= '0;
      addr_cnt       <= '0;
      pipe_valid     <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      aborted        <= 1'b0;
    end else if (abort) begin
      // Results so far are kept; reads still in the memory pipe are dropped.
      pipe_valid <= '0;
      aborted    <= 1'b1;
    end else begin
      case (state)
        S_WAIT:  cnt <= cnt + 1'b1;
        S_READ: begin
          cnt <= '0;
          if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + 1'b1;
        end
        S_DRAIN: cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase

      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
      end
      pipe_valid[0] <= bram_enb;
      pipe_addr[0]  <= addr_cnt;

      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          first_err_addr <= tap_addr;
          first_err_data <= bram_doutb;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_read_checker.sv
// Bench for bram_read_checker: two instances (read latency 1 and 3) fed by a
// shared pattern memory, checked against a whole-memory reference scan.
module tb_bram_read_checker;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int SD = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, locked, start1, start3;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          enb1, enb3, busy1, busy3, done1, done3, pass1, pass3, ab1, ab3;
  logic [AW-1:0] addr1, addr3, fea1, fea3;
  logic [DW-1:0] dout1, dout3, fed1, fed3, p0, p1;
  logic [15:0]   err1, err3;
  logic [2:0]    st1, st3;

  logic [DW-1:0] mem [DEPTH];

  bram_read_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(1), .START_DELAY(SD)) dut1 (
    .clk_100mhz(clk), .reset(reset), .locked(locked), .start(start1),
    .bram_enb(enb1), .bram_addrb(addr1), .bram_doutb(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .aborted(ab1), .err_count(err1),
    .first_err_addr(fea1), .first_err_data(fed1), .fsm_state(st1));

  bram_read_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(3), .START_DELAY(SD)) dut3 (
    .clk_100mhz(clk), .reset(reset), .locked(locked), .start(start3),
    .bram_enb(enb3), .bram_addrb(addr3), .bram_doutb(dout3),
    .busy(busy3), .done(done3), .pass(pass3), .aborted(ab3), .err_count(err3),
    .first_err_addr(fea3), .first_err_data(fed3), .fsm_state(st3));

  // Memory models: one-cycle and three-cycle read pipelines over the same array.
  always @(posedge clk) if (enb1) dout1 <= mem[addr1];
  always @(posedge clk) begin
    if (enb3) p0 <= mem[addr3];
    p1    <= p0;
    dout3 <= p1;
  end

  // Observation mux for the instance under test.
  int            sel = 1;
  logic          m_enb, m_busy, m_done, m_pass, m_ab;
  logic [AW-1:0] m_addr, m_fea;
  logic [DW-1:0] m_fed;
  logic [15:0]   m_err;
  always_comb begin
    m_enb  = (sel == 3) ? enb3  : enb1;
    m_busy = (sel == 3) ? busy3 : busy1;
    m_done = (sel == 3) ? done3 : done1;
    m_pass = (sel == 3) ? pass3 : pass1;
    m_ab   = (sel == 3) ? ab3   : ab1;
    m_addr = (sel == 3) ? addr3 : addr1;
    m_fea  = (sel == 3) ? fea3  : fea1;
    m_fed  = (sel == 3) ? fed3  : fed1;
    m_err  = (sel == 3) ? err3  : err1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            acyc_q[$];

  always @(negedge clk) if (m_enb) begin
    addr_q.push_back(m_addr);
    acyc_q.push_back(cyc);
  end

  typedef struct {
    bit            ok;
    int            start_cyc, done_cyc, busy_cycles, first_rd, last_rd;
    bit            seq_ok;
    logic          done, pass, aborted;
    logic [15:0]   err;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    logic [AW-1:0] addr_at_done;
  } res_t;

  // Reference model: scan the whole memory for words that are not a*2.
  task automatic model_expect(output int n, output logic [AW-1:0] fa, output logic [DW-1:0] fd);
    n = 0; fa = '0; fd = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== DW'(a * 2)) begin
        if (n == 0) begin fa = AW'(a); fd = mem[a]; end
        n++;
      end
    end
    if (n > 65535) n = 65535;
  endtask

  task automatic fill_clean();
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a * 2);
  endtask

  task automatic corrupt(input int a);
    logic [DW-1:0] v;
    v = $urandom;
    if (v == DW'(a * 2)) v = v ^ 32'h1;
    mem[a] = v;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int st_cyc);
    @(negedge clk);
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic run_sweep(output res_t r);
    addr_q.delete(); acyc_q.delete(); exp_q.delete();
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(AW'(a));
    pulse_start(r.start_cyc);
    r.ok = 0; r.done_cyc = 0; r.busy_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_done) begin r.ok = 1; r.done_cyc = cyc; break; end
      if (m_busy) r.busy_cycles++;
      @(negedge clk);
    end
    r.done = m_done; r.pass = m_pass; r.aborted = m_ab; r.err = m_err;
    r.fa = m_fea; r.fd = m_fed; r.addr_at_done = m_addr;
    r.seq_ok = (addr_q.size() == exp_q.size());
    if (r.seq_ok)
      for (int i = 0; i < DEPTH; i++)
        if (addr_q[i] !== exp_q[i] || (i > 0 && acyc_q[i] != acyc_q[i-1] + 1)) r.seq_ok = 0;
    r.first_rd = (acyc_q.size() > 0) ? acyc_q[0] - r.start_cyc : -1;
    r.last_rd  = (acyc_q.size() > 0) ? acyc_q[acyc_q.size()-1] : -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({enb1, addr1, busy1, done1, pass1, ab1, err1, fea1, fed1} !== '0) begin errors++; $display("FAIL reset_dut1 got %h want 0", {enb1, addr1, busy1, done1, pass1, ab1, err1, fea1, fed1}); end
    checks++; if ({enb3, addr3, busy3, done3, pass3, ab3, err3, fea3, fed3} !== '0) begin errors++; $display("FAIL reset_dut3 got %h want 0", {enb3, addr3, busy3, done3, pass3, ab3, err3, fea3, fed3}); end
    checks++; if (st1 !== 3'd0 || st3 !== 3'd0) begin errors++; $display("FAIL reset_state got %0d/%0d want 0/0", st1, st3); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    res_t r;
    sel = 1; fill_clean();
    run_sweep(r);
    checks++; if (r.ok !== 1'b1) begin errors++; $display("FAIL clean_timeout got no done want done"); end
    checks++; if (r.done_cyc - r.start_cyc != SD + DEPTH + 2) begin errors++; $display("FAIL clean_done_lat got %0d want %0d", r.done_cyc - r.start_cyc, SD + DEPTH + 2); end
    checks++; if (r.busy_cycles != SD + DEPTH + 1) begin errors++; $display("FAIL clean_busy got %0d want %0d", r.busy_cycles, SD + DEPTH + 1); end
    checks++; if (r.first_rd != SD + 1) begin errors++; $display("FAIL clean_first_rd got %0d want %0d", r.first_rd, SD + 1); end
    checks++; if (r.seq_ok !== 1'b1) begin errors++; $display("FAIL clean_addr_seq got %0d addrs want 0..%0d once", addr_q.size(), DEPTH - 1); end
    checks++; if ({r.done, r.pass, r.aborted} !== 3'b110) begin errors++; $display("FAIL clean_flags got %b want 110", {r.done, r.pass, r.aborted}); end
    checks++; if (r.err !== 16'd0 || r.fa !== '0 || r.fd !== '0) begin errors++; $display("FAIL clean_errs got %0d/%0d/%h want 0/0/0", r.err, r.fa, r.fd); end
    checks++; if (r.addr_at_done !== AW'(DEPTH - 1) || m_enb !== 1'b0) begin errors++; $display("FAIL clean_addr_hold got %0d enb %b want %0d enb 0", r.addr_at_done, m_enb, DEPTH - 1); end
  endtask

  task automatic test_single_corrupt();
    res_t r; int n; logic [AW-1:0] fa; logic [DW-1:0] fd;
    sel = 1; fill_clean(); mem[37] = 32'h0000_FFFF;
    model_expect(n, fa, fd);
    run_sweep(r);
    checks++; if ({r.ok, r.done, r.pass} !== 3'b110) begin errors++; $display("FAIL single_flags got %b want 110", {r.ok, r.done, r.pass}); end
    checks++; if (r.err !== 16'(n)) begin errors++; $display("FAIL single_count got %0d want %0d", r.err, n); end
    checks++; if (r.fa !== fa || r.fd !== fd) begin errors++; $display("FAIL single_first got %0d/%h want %0d/%h", r.fa, r.fd, fa, fd); end
  endtask

  task automatic test_two_then_fixed();
    res_t r; int n; logic [AW-1:0] fa; logic [DW-1:0] fd;
    sel = 1; fill_clean(); corrupt(5); corrupt(900);
    model_expect(n, fa, fd);
    run_sweep(r);
    checks++; if (r.err !== 16'(n) || r.pass !== 1'b0) begin errors++; $display("FAIL two_count got %0d pass %b want %0d pass 0", r.err, r.pass, n); end
    checks++; if (r.fa !== fa || r.fd !== fd) begin errors++; $display("FAIL two_first got %0d/%h want %0d/%h", r.fa, r.fd, fa, fd); end
    fill_clean();
    run_sweep(r);
    checks++; if ({r.ok, r.done, r.pass} !== 3'b111 || r.err !== 16'd0) begin errors++; $display("FAIL fixed_rerun got %b err %0d want 111 err 0", {r.ok, r.done, r.pass}, r.err); end
    checks++; if (r.fa !== '0 || r.fd !== '0) begin errors++; $display("FAIL fixed_first_clear got %0d/%h want 0/0", r.fa, r.fd); end
  endtask

  task automatic test_random();
    res_t r; int n; logic [AW-1:0] fa; logic [DW-1:0] fd;
    sel = 1;
    for (int it = 0; it < 4; it++) begin
      fill_clean();
      for (int k = $urandom_range(0, 12); k > 0; k--) corrupt($urandom_range(0, DEPTH - 1));
      if (it == 0) corrupt(DEPTH - 1);
      model_expect(n, fa, fd);
      run_sweep(r);
      checks++; if (r.err !== 16'(n) || r.pass !== (n == 0)) begin errors++; $display("FAIL rand%0d_count got %0d pass %b want %0d pass %b", it, r.err, r.pass, n, n == 0); end
      checks++; if (r.fa !== fa || r.fd !== fd) begin errors++; $display("FAIL rand%0d_first got %0d/%h want %0d/%h", it, r.fa, r.fd, fa, fd); end
    end
  endtask

  task automatic test_latency3();
    res_t r; int n; logic [AW-1:0] fa; logic [DW-1:0] fd;
    sel = 3; fill_clean();
    run_sweep(r);
    checks++; if ({r.ok, r.done, r.pass} !== 3'b111 || r.err !== 16'd0) begin errors++; $display("FAIL lat3_clean got %b err %0d want 111 err 0", {r.ok, r.done, r.pass}, r.err); end
    checks++; if (r.done_cyc - r.start_cyc != SD + DEPTH + 4) begin errors++; $display("FAIL lat3_done_lat got %0d want %0d", r.done_cyc - r.start_cyc, SD + DEPTH + 4); end
    checks++; if (r.done_cyc - r.last_rd != 4) begin errors++; $display("FAIL lat3_drain got %0d want 4", r.done_cyc - r.last_rd); end
    checks++; if (r.first_rd != SD + 1 || r.seq_ok !== 1'b1) begin errors++; $display("FAIL lat3_reads got first %0d seq %b want %0d seq 1", r.first_rd, r.seq_ok, SD + 1); end
    corrupt(0); corrupt(DEPTH - 1); corrupt($urandom_range(1, DEPTH - 2));
    model_expect(n, fa, fd);
    run_sweep(r);
    checks++; if (r.err !== 16'(n) || r.fa !== fa || r.fd !== fd) begin errors++; $display("FAIL lat3_errs got %0d/%0d/%h want %0d/%0d/%h", r.err, r.fa, r.fd, n, fa, fd); end
    sel = 1;
  endtask

  task automatic test_abort();
    res_t r; int st; bit hit;
    sel = 1; fill_clean(); mem[10] = 32'hDEAD_BEEF;
    pulse_start(st);
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_enb && m_addr == AW'(400)) begin hit = 1; break; end
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach got no addr 400 want addr 400"); end
    locked = 1'b0;
    @(negedge clk);
    checks++; if ({m_busy, m_enb, m_ab, m_done} !== 4'b0010) begin errors++; $display("FAIL abort_flags got %b want 0010", {m_busy, m_enb, m_ab, m_done}); end
    checks++; if (m_err !== 16'd1 || m_fea !== AW'(10) || m_fed !== 32'hDEAD_BEEF) begin errors++; $display("FAIL abort_hold got %0d/%0d/%h want 1/10/deadbeef", m_err, m_fea, m_fed); end
    checks++; if (st1 !== 3'd0) begin errors++; $display("FAIL abort_state got %0d want 0", st1); end
    pulse_start(st);
    checks++; if (m_busy !== 1'b0 || m_ab !== 1'b1) begin errors++; $display("FAIL unlocked_start got busy %b ab %b want busy 0 ab 1", m_busy, m_ab); end
    locked = 1'b1; fill_clean();
    run_sweep(r);
    checks++; if ({r.ok, r.done, r.pass, r.aborted} !== 4'b1110 || r.err !== 16'd0 || r.seq_ok !== 1'b1) begin errors++; $display("FAIL abort_recover got %b err %0d seq %b want 1110 err 0 seq 1", {r.ok, r.done, r.pass, r.aborted}, r.err, r.seq_ok); end
  endtask

  task automatic test_restart_ignored();
    res_t r; int n; logic [AW-1:0] fa; logic [DW-1:0] fd;
    sel = 1; fill_clean(); corrupt(123);
    model_expect(n, fa, fd);
    fork
      run_sweep(r);
      begin
        repeat (12) @(negedge clk);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        repeat (500) @(negedge clk);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      end
    join
    checks++; if (r.done_cyc - r.start_cyc != SD + DEPTH + 2 || r.busy_cycles != SD + DEPTH + 1) begin errors++; $display("FAIL restart_timing got %0d/%0d want %0d/%0d", r.done_cyc - r.start_cyc, r.busy_cycles, SD + DEPTH + 2, SD + DEPTH + 1); end
    checks++; if (r.seq_ok !== 1'b1 || r.first_rd != SD + 1) begin errors++; $display("FAIL restart_seq got seq %b first %0d want seq 1 first %0d", r.seq_ok, r.first_rd, SD + 1); end
    checks++; if (r.err !== 16'(n) || r.fa !== fa || r.fd !== fd) begin errors++; $display("FAIL restart_errs got %0d/%0d/%h want %0d/%0d/%h", r.err, r.fa, r.fd, n, fa, fd); end
  endtask

  task automatic test_reset_mid();
    res_t r; int st; bit hit;
    sel = 1; fill_clean(); corrupt(20);
    pulse_start(st);
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_enb && m_addr == AW'(300)) begin hit = 1; break; end
      @(negedge clk);
    end
    checks++; if (!hit || m_err !== 16'd1) begin errors++; $display("FAIL rstmid_reach got hit %b err %0d want hit 1 err 1", hit, m_err); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({enb1, addr1, busy1, done1, pass1, ab1, err1, fea1, fed1} !== '0) begin errors++; $display("FAIL rstmid_async got %h want 0", {enb1, addr1, busy1, done1, pass1, ab1, err1, fea1, fed1}); end
    @(negedge clk); reset = 1'b1;
    fill_clean();
    run_sweep(r);
    checks++; if ({r.ok, r.done, r.pass} !== 3'b111 || r.err !== 16'd0) begin errors++; $display("FAIL rstmid_recover got %b err %0d want 111 err 0", {r.ok, r.done, r.pass}, r.err); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    reset = 1'b0; locked = 1'b1; start1 = 1'b0; start3 = 1'b0;
    fill_clean();
    test_reset();
    test_clean();
    test_single_corrupt();
    test_two_then_fixed();
    test_random();
    test_latency3();
    test_abort();
    test_restart_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
